// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider.
//
// Divides the input clock fin by N = div_val (1..2^W-1). A new divisor is
// loaded only at terminal count, so a ratio change never cuts a period short
// and never produces a runt pulse. div_val = 0 stops the divider at the end
// of the current period.
//
// Ports:
//   fin      in   input clock; all state updates on posedge fin
//   rst      in   asynchronous active-high reset
//   en       in   divider enable (synchronous to fin)
//   div_val  in   [W] requested divisor, 0 = stop (synchronous to fin)
//   fout     out  registered divided clock, high while cnt < ceil(act/2)
//   tick     out  registered one-cycle strobe in the last cycle of a period
//   running  out  high while the divider is in the run state
//   div_cur  out  [W] divisor currently in effect

module clk_div_prog #(
  parameter int unsigned W         = 8,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic         fin,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_val,
  output logic         fout,
  output logic         tick,
  output logic         running,
  output logic [W-1:0] div_cur
);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] act_q, act_d;
  logic         fout_q, fout_d;
  logic         tick_q, tick_d;

  logic [W-1:0] cnt_inc;
  logic [W-1:0] act_m1;
  logic [W:0]   half;

  // act >= 1 whenever running, so act - 1 never wraps in the run state.
  assign cnt_inc = cnt_q + {{(W-1){1'b0}}, 1'b1};
  assign act_m1  = act_q - {{(W-1){1'b0}}, 1'b1};
  // ceil(act/2) computed one bit wider so act = 2^W-1 does not wrap to 0.
  assign half    = ({1'b0, act_q} + {{W{1'b0}}, 1'b1}) >> 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    fout_d  = fout_q;
    tick_d  = tick_q;

    case (state_q)
      StIdle: begin
        cnt_d  = '0;
        fout_d = 1'b0;
        tick_d = 1'b0;
        act_d  = div_val;
        if (en && (div_val != '0)) begin
          state_d = StRun;
          fout_d  = 1'b1;
          tick_d  = (div_val == {{(W-1){1'b0}}, 1'b1});
        end
      end

      StRun: begin
        if (!en) begin
          // Abandon the partial period.
          state_d = StIdle;
          cnt_d   = '0;
          fout_d  = 1'b0;
          tick_d  = 1'b0;
        end else if (cnt_q == act_m1) begin
          // Terminal count: the only point where a new divisor is accepted.
          cnt_d = '0;
          act_d = div_val;
          if (div_val == '0) begin
            state_d = StIdle;
            fout_d  = 1'b0;
            tick_d  = 1'b0;
          end else begin
            fout_d = 1'b1;
            tick_d = (div_val == {{(W-1){1'b0}}, 1'b1});
          end
        end else begin
          cnt_d  = cnt_inc;
          fout_d = ({1'b0, cnt_inc} < half);
          tick_d = (cnt_inc == act_m1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        fout_d  = 1'b0;
        tick_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      act_q   <= W'(RESET_DIV);
      fout_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      fout_q  <= fout_d;
      tick_q  <= tick_d;
    end
  end

  assign fout    = fout_q;
  assign tick    = tick_q;
  assign running = (state_q == StRun);
  assign div_cur = act_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (W = 8, RESET_DIV = 2).
// Inputs are driven and outputs sampled on the falling edge of fin.

module tb_clk_div_prog;

  logic       fin;
  logic       rst;
  logic       en;
  logic [7:0] div_val;
  logic       fout;
  logic       tick;
  logic       running;
  logic [7:0] div_cur;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_prog #(
    .W        (8),
    .RESET_DIV(2)
  ) dut (
    .fin    (fin),
    .rst    (rst),
    .en     (en),
    .div_val(div_val),
    .fout   (fout),
    .tick   (tick),
    .running(running),
    .div_cur(div_cur)
  );

  initial fin = 1'b0;
  always #5 fin = ~fin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Checks n consecutive cycles; pattern bit n-1 is the first cycle.
  task automatic check_period(input string tag, input int n, input logic [7:0] fpat,
                              input logic [7:0] tpat, input logic [7:0] dc);
    for (int k = 0; k < n; k++) begin
      @(negedge fin);
      check({tag, "_fout"}, {31'd0, fout}, {31'd0, fpat[n-1-k]});
      check({tag, "_tick"}, {31'd0, tick}, {31'd0, tpat[n-1-k]});
      check({tag, "_run"}, {31'd0, running}, 32'd1);
      check({tag, "_cur"}, {24'd0, div_cur}, {24'd0, dc});
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] dc);
    check({tag, "_fout"}, {31'd0, fout}, 32'd0);
    check({tag, "_tick"}, {31'd0, tick}, 32'd0);
    check({tag, "_run"}, {31'd0, running}, 32'd0);
    check({tag, "_cur"}, {24'd0, div_cur}, {24'd0, dc});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hi_cnt;
    rst     = 1'b1;
    en      = 1'b0;
    div_val = 8'd0;
    repeat (2) @(negedge fin);
    check_idle("reset", 8'd2);
    rst = 1'b0;

    // Start with N = 4.
    div_val = 8'd4;
    en      = 1'b1;
    check_period("n4", 4, 8'b1100, 8'b0001, 8'd4);
    check_period("n4b", 4, 8'b1100, 8'b0001, 8'd4);

    // Asynchronous reset in the middle of the high phase.
    @(posedge fin);
    #2;
    check("pre_rst_fout", {31'd0, fout}, 32'd1);
    rst = 1'b1;
    #1;
    check_idle("async_rst", 8'd2);
    en = 1'b0;
    @(negedge fin);
    rst = 1'b0;
    @(negedge fin);
    check_idle("idle_track", 8'd4);

    // Odd ratio.
    div_val = 8'd5;
    en      = 1'b1;
    check_period("n5", 5, 8'b11100, 8'b00001, 8'd5);
    check_period("n5b", 5, 8'b11100, 8'b00001, 8'd5);

    // Reload 6 -> 3 requested mid-period.
    div_val = 8'd6;
    check_period("n6a", 3, 8'b111, 8'b000, 8'd6);
    div_val = 8'd3;
    check_period("n6b", 3, 8'b000, 8'b001, 8'd6);
    check_period("n3", 3, 8'b110, 8'b001, 8'd3);
    check_period("n3b", 3, 8'b110, 8'b001, 8'd3);

    // N = 1: both outputs constantly high.
    div_val = 8'd1;
    check_period("n1", 4, 8'b1111, 8'b1111, 8'd1);

    // N = 255: 128 cycles high, tick only in the last one.
    div_val = 8'd255;
    hi_cnt  = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge fin);
      if (fout) hi_cnt++;
      check("n255_tick", {31'd0, tick}, (k == 254) ? 32'd1 : 32'd0);
      check("n255_run", {31'd0, running}, 32'd1);
      if (k == 127) check("n255_fout_last_hi", {31'd0, fout}, 32'd1);
      if (k == 128) check("n255_fout_first_lo", {31'd0, fout}, 32'd0);
    end
    check("n255_high_cycles", hi_cnt, 32'd128);
    check("n255_cur", {24'd0, div_cur}, 32'd255);

    // Stop via div_val = 0 in the middle of an N = 4 period.
    div_val = 8'd4;
    check_period("stop_a", 2, 8'b11, 8'b00, 8'd4);
    div_val = 8'd0;
    check_period("stop_b", 2, 8'b00, 8'b01, 8'd4);
    @(negedge fin);
    check_idle("stopped", 8'd0);

    // en = 1 with div_val = 0 stays idle; then start with 3.
    repeat (2) @(negedge fin);
    check_idle("zero_start", 8'd0);
    div_val = 8'd3;
    check_period("start3", 3, 8'b110, 8'b001, 8'd3);

    // Enable abort at cnt = 1 of N = 8, then restart from cnt = 0.
    div_val = 8'd8;
    check_period("n8a", 2, 8'b11, 8'b00, 8'd8);
    en = 1'b0;
    @(negedge fin);
    check_idle("abort", 8'd8);
    en = 1'b1;
    check_period("n8", 8, 8'b11110000, 8'b00000001, 8'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
